dram_lsu: RTL
=============

DRAM_LSU -- requirements
Module: dram_lsu

Interface
REQ-001 Parameter ADDR_W, default 8, DRAM word-address width.
REQ-002 Parameter DATA_W, default 16, DRAM data width.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  processor request present.
REQ-006 req_ready  output  1  LSU accepts a request; a request transfers on an edge with req_valid&req_ready.
REQ-007 req_we  input  1  1=store, 0=load.
REQ-008 req_addr  input  ADDR_W  start word address.
REQ-009 req_len  input  4  load burst length minus one (0 gives 1 beat, 15 gives 16 beats); ignored for stores.
REQ-010 req_wdata  input  DATA_W  store data.
REQ-011 rsp_valid  output  1  load data beat available.
REQ-012 rsp_ready  input  1  consumer takes the beat on an edge with rsp_valid&rsp_ready.
REQ-013 rsp_rdata  output  DATA_W  load data beat.
REQ-014 rsp_last  output  1  marks the final beat of a burst.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 mem_address  output  ADDR_W  to DRAM address.
REQ-017 mem_data  output  DATA_W  to DRAM data.
REQ-018 mem_wren  output  1  to DRAM wren.
REQ-019 mem_q  input  DATA_W  from DRAM q; valid one cycle after mem_address is clocked into the DRAM.

Function
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, CAPT and RESP; req_ready is 1 only in IDLE.
REQ-021 On an accepted store in IDLE, the LSU SHALL drive mem_address, mem_data and mem_wren=1 for exactly the next cycle (ISSUE), return to IDLE and produce no response.
REQ-022 On an accepted load, the transitions SHALL be ISSUE (mem_address=current address, mem_wren=0), then CAPT (mem_q registered into rsp_rdata at the end of CAPT), then RESP.
REQ-023 rsp_valid SHALL rise exactly 3 cycles after the accept edge for the first beat of a load.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_last SHALL hold stable until rsp_ready; on handshake the FSM goes to ISSUE for the next beat, or to IDLE after the last beat.
REQ-025 Each subsequent load beat SHALL use address+1, computed modulo 2^ADDR_W (address 255 wraps to 0).
REQ-026 A 4-bit beat counter SHALL load req_len on accept and decrement per beat; rsp_last = (counter==0) in RESP.
REQ-027 mem_wren SHALL be 0 in every state except a store ISSUE cycle.
REQ-028 When idle, mem_address and mem_data SHALL hold their last driven values.
REQ-029 req_valid asserted while the LSU is busy SHALL be ignored, with no capture, until IDLE.
REQ-030 On the edge that completes the last-beat handshake, a request pending on req_valid SHALL NOT be accepted; it is accepted at the earliest on the following edge.

Reset
REQ-031 While resetn=0 at an edge, the LSU SHALL set state=IDLE, rsp_valid=0, rsp_last=0, rsp_rdata=0, mem_wren=0, mem_address=0, mem_data=0 and counter=0.
REQ-032 A reset asserted mid-burst or mid-store SHALL abort the operation and discard the pending beat, and mem_wren SHALL be 0 from the first reset edge; DRAM contents are not rolled back.
REQ-033 req_ready SHALL be 0 while resetn=0 and SHALL be 1 on the first cycle after reset is released.

Structure
REQ-034 The package dram_pkg SHALL hold ADDR_W and DATA_W defaults and the FSM state enumeration.
REQ-035 The LSU SHALL have no sub-module; the parent instances DRAM beside it and connects mem_* to DRAM address, data, wren and q.

Verification
REQ-036 Store 0x1234 to address 0x10, then load address 0x10 with len 0 -> rsp_rdata=0x1234, rsp_last=1, and rsp_valid 3 cycles after the accept edge.
REQ-037 Store 0xAAAA at 0xFE, 0xBBBB at 0xFF and 0xCCCC at 0x00, then load 0xFE with len 2 -> beats 0xAAAA, 0xBBBB, 0xCCCC with rsp_last on the third beat only.
REQ-038 Load with len 3 while rsp_ready is held low for 5 cycles on beat 2 -> rsp_rdata and rsp_valid are stable throughout, no beat is lost or duplicated, and mem_wren stays 0.
REQ-039 req_valid held high continuously with alternating store/load -> req_ready is high only in IDLE, each request is accepted exactly once, and mem_wren is high for exactly 1 cycle per store.
REQ-040 resetn pulled low during beat 2 of a len-7 load -> rsp_valid=0 and busy=0 after the reset edge, req_ready=1 after release, and a following load of a known address returns correct data.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared defaults and FSM encoding for the DRAM load/store unit.
package dram_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/dram_lsu.sv
// Load/store unit fronting a synchronous-read DRAM: single-word stores and
// incrementing-address load bursts of 1..16 beats with a valid/ready response.
module dram_lsu
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  lsu_state_e state_q, state_d;
  logic       is_store_q;
  logic [3:0] cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   state_d = is_store_q ? IDLE : CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = (cnt_q == '0) ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // The ready term includes resetn so nothing is offered while reset is held.
  assign req_ready = (state_q == IDLE) && resetn;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_last  = (state_q == RESP) && (cnt_q == '0);

  // mem_address doubles as the burst address register; it is only moved on
  // accept and between beats, so it holds its last value while idle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      cnt_q       <= '0;
      rsp_rdata   <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_wren <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_address <= req_addr;
            mem_wren    <= req_we;
            is_store_q  <= req_we;
            cnt_q       <= req_len;
            if (req_we) mem_data <= req_wdata;
          end
        end
        CAPT: rsp_rdata <= mem_q;
        RESP: begin
          if (rsp_ready && (cnt_q != '0)) begin
            cnt_q       <= cnt_q - 4'd1;
            mem_address <= mem_address + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
